// File: rtl/player_ctrl.sv
// player_ctrl: conditions the raw play/stop buttons (2-flop sync, debounce,
// rising-edge detect) and runs the STOPPED/PLAYING/PAUSED transport FSM with
// a timed auto-advance track counter. Every transport transition emits exactly
// one registered one-cycle play or stop pulse so the LED indicator FSM
// downstream stays in lockstep with this one.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_STOPPED | idle, track=0, counters cleared; only play_req acts
// S_PLAYING | tick/step counters run; step wrap may advance track or stop
// S_PAUSED  | counters frozen at their current values until resume/stop
module player_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICK_DIV        = 8,
  parameter int STEP_TICKS      = 3,
  parameter int NUM_TRACKS      = 4,
  parameter int TRACK_W         = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_play,
  input  logic               btn_stop,
  input  logic               auto_en,
  input  logic               loop_en,
  output logic               play,
  output logic               stop,
  output logic [1:0]         state,
  output logic [TRACK_W-1:0] track,
  output logic               track_adv
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_TICKS - 1);
  localparam logic [TRACK_W-1:0] TRACK_LAST = TRACK_W'(NUM_TRACKS - 1);

  typedef enum logic [1:0] {
    S_STOPPED = 2'b00,
    S_PLAYING = 2'b01,
    S_PAUSED  = 2'b10
  } state_t;

  // Button conditioning: bit 0 is play, bit 1 is stop.
  logic [1:0]            sync1_q, sync1_d;
  logic [1:0]            sync2_q, sync2_d;
  logic [1:0][DB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [1:0]            deb_lvl_q, deb_lvl_d;
  logic [1:0]            deb_prev_q, deb_prev_d;
  logic                  play_req;
  logic                  stop_req;

  // Transport state.
  state_t                state_q, state_d;
  logic [TRACK_W-1:0]    track_q, track_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  play_q, play_d;
  logic                  stop_q, stop_d;
  logic                  adv_q, adv_d;
  logic                  tick;
  logic                  step_wrap;

  // Synchroniser next values: shift the raw buttons through two stages.
  always_comb begin
    sync1_d = {btn_stop, btn_play};
    sync2_d = sync1_q;
  end

  // Debounce: a level change must persist DEBOUNCE_CYCLES clocks to be taken.
  always_comb begin
    deb_cnt_d  = '0;
    deb_lvl_d  = deb_lvl_q;
    deb_prev_d = deb_lvl_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DB_LAST) begin
          deb_lvl_d[i] = sync2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign play_req = deb_lvl_q[0] & ~deb_prev_q[0];
  assign stop_req = deb_lvl_q[1] & ~deb_prev_q[1];

  // Conditioning registers; levels start at 0 so a button held through reset
  // release looks like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= '0;
      deb_prev_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_prev_d;
    end
  end

  assign tick      = (state_q == S_PLAYING) && (tick_q == TICK_LAST);
  assign step_wrap = tick && (step_q == STEP_LAST);

  // Transport FSM next state, counters and pulse outputs.
  always_comb begin
    state_d = state_q;
    track_d = track_q;
    tick_d  = tick_q;
    step_d  = step_q;
    play_d  = 1'b0;
    stop_d  = 1'b0;
    adv_d   = 1'b0;
    unique case (state_q)
      S_STOPPED: begin
        // Coincident play/stop requests are both ignored while stopped.
        if (play_req && !stop_req) begin
          state_d = S_PLAYING;
          play_d  = 1'b1;
          tick_d  = '0;
          step_d  = '0;
        end
      end
      S_PLAYING: begin
        if (stop_req) begin
          state_d = S_STOPPED;
          stop_d  = 1'b1;
          track_d = '0;
          tick_d  = '0;
          step_d  = '0;
        end else if (play_req) begin
          // Counters hold, so a pause on the wrap cycle replays the wrap
          // on the first tick after resume.
          state_d = S_PAUSED;
          play_d  = 1'b1;
        end else begin
          tick_d = tick ? '0 : tick_q + 1'b1;
          if (tick) begin
            step_d = step_wrap ? '0 : step_q + 1'b1;
          end
          if (step_wrap && auto_en) begin
            if (track_q < TRACK_LAST) begin
              track_d = track_q + 1'b1;
              adv_d   = 1'b1;
            end else if (loop_en) begin
              track_d = '0;
              adv_d   = 1'b1;
            end else begin
              state_d = S_STOPPED;
              stop_d  = 1'b1;
              track_d = '0;
              tick_d  = '0;
              step_d  = '0;
            end
          end
        end
      end
      S_PAUSED: begin
        if (stop_req) begin
          state_d = S_STOPPED;
          stop_d  = 1'b1;
          track_d = '0;
          tick_d  = '0;
          step_d  = '0;
        end else if (play_req) begin
          state_d = S_PLAYING;
          play_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_STOPPED;
        track_d = '0;
        tick_d  = '0;
        step_d  = '0;
      end
    endcase
  end

  // Transport registers; reset clears everything with no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_STOPPED;
      track_q <= '0;
      tick_q  <= '0;
      step_q  <= '0;
      play_q  <= 1'b0;
      stop_q  <= 1'b0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      track_q <= track_d;
      tick_q  <= tick_d;
      step_q  <= step_d;
      play_q  <= play_d;
      stop_q  <= stop_d;
      adv_q   <= adv_d;
    end
  end

  assign play      = play_q;
  assign stop      = stop_q;
  assign state     = state_q;
  assign track     = track_q;
  assign track_adv = adv_q;

endmodule

// File: doc/player_ctrl.md
Name: player_ctrl

Overview:
Front-end controller for the play/stop LED indicator state machine. It conditions the raw play/stop push-buttons with a synchroniser, debouncer and edge detector. It runs a STOPPED/PLAYING/PAUSED transport FSM with a timed auto-advance track counter. It emits one-cycle play/stop pulses that keep the LED indicator in lockstep: one pulse per transport transition, never more.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clocks a synchronised button level must differ from its debounced level before it is accepted
TICK_DIV, 8, clocks per playback tick (PLAYING only)
STEP_TICKS, 3, ticks per track before auto-advance
NUM_TRACKS, 4, track count; 2 <= NUM_TRACKS <= 2**TRACK_W
TRACK_W, 2, width of track output

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
btn_play  in  1  raw play button, active-high, asynchronous to clk
btn_stop  in  1  raw stop button, active-high, asynchronous to clk
auto_en  in  1  enables auto-advance of track
loop_en  in  1  1: wrap from last track to 0 and keep playing; 0: stop at end of list
play  out  1  one-cycle pulse to LED indicator, registered
stop  out  1  one-cycle pulse to LED indicator, registered
state  out  2  00 STOPPED, 01 PLAYING, 10 PAUSED (11 never driven)
track  out  TRACK_W  current track index
track_adv  out  1  one-cycle pulse on every auto-advance

Behaviour:
- Reset (async assert, sync release): state=STOPPED, track=0, play=stop=track_adv=0. Tick counter, step counter, sync flops, debounce counters and debounced levels are all 0.
- Per button: 2-flop synchroniser, then a debounce counter.
- Debounce counter: clears whenever the synchronised level equals the debounced level. Otherwise it increments; when it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- A rising edge of a debounced level gives a one-cycle internal request (play_req / stop_req). Falling edges generate nothing.
- Latency: with the button held stable from first sampling edge E0, the corresponding request is acted on and its output pulse is high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
- Any high glitch shorter than DEBOUNCE_CYCLES synchronised clocks produces no request.
- A button held high through reset release is treated as a new press and produces a request after the normal latency.
- FSM (all outputs registered, pulses one cycle wide):
  STOPPED: play_req -> PLAYING, pulse play, tick=0, step=0. stop_req ignored, no pulse.
  PLAYING: stop_req -> STOPPED, pulse stop, track=0, counters=0. Else play_req -> PAUSED, pulse play, counters frozen.
  PAUSED: stop_req -> STOPPED, pulse stop, track=0, counters=0. Else play_req -> PLAYING, pulse play, counters resume from frozen values.
- Simultaneous play_req and stop_req: stop wins; exactly one stop pulse. In STOPPED both are ignored.
- Tick counter (PLAYING only): counts 0..TICK_DIV-1; tick is asserted when the count equals TICK_DIV-1, then the count wraps to 0.
- Step counter: increments on tick; on tick at value STEP_TICKS-1 it wraps to 0, forming the "step wrap" event. Counters also run when auto_en=0.
- On step wrap with auto_en=1:
  track < NUM_TRACKS-1: track+1, pulse track_adv.
  track = NUM_TRACKS-1 and loop_en=1: track=0, pulse track_adv, stay PLAYING.
  track = NUM_TRACKS-1 and loop_en=0: -> STOPPED, pulse stop, track=0, no track_adv.
- On step wrap with auto_en=0: nothing happens.
- auto_en and loop_en are sampled only on the step-wrap cycle.
- Request coincident with step wrap:
  stop_req: normal stop, advance discarded, single stop pulse.
  play_req: transition to PAUSED, advance discarded, counters freeze at TICK_DIV-1 / STEP_TICKS-1. The advance fires on the first tick after resume.
- At most one of play/stop is high in any cycle.
- Reset asserted mid-operation returns all state to reset values immediately, with no pulse emitted.

Test Plan:
- Reset, then a clean btn_play press held for 10 cycles -> one play pulse in the cycle after edge E0+6; state=01; no further pulses while held.
- btn_play high for 3 cycles (< DEBOUNCE_CYCLES) -> no play pulse; state stays 00.
- PLAYING with auto_en=1, loop_en=1, track=0, run 96 cycles -> track_adv pulses every 24 cycles; track 1,2,3,0; state stays 01.
- Same with loop_en=0 from track=3 -> after 24 cycles, stop pulse, state=00, track=0, no track_adv.
- PLAYING, press play (-> 10), wait 50 cycles -> track and counters unchanged. Press play again -> 01, and the next advance arrives after the remaining cycles of the 24-cycle period.
- Presses on both buttons debounced in the same cycle while PLAYING -> a single stop pulse, no play pulse, state=00. Assert rst mid-PLAYING -> all outputs 0 immediately.
